// File: rtl/ddr2_sys_ddr2_dmaster_st_channel_arbiter_pkg.sv
// Shared definitions for the debug-master ST channel arbiter.
//   arb_state_t : packet FSM encoding (IDLE = arbitrating, LOCKED = mid-packet)
//   DROP_MAX    : saturation value of the orphan drop counter
//   sat_inc8    : saturating 8-bit increment
package ddr2_sys_ddr2_dmaster_st_channel_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ddr2_sys_ddr2_dmaster_st_channel_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per source
//   rr_ptr  : index of the highest-priority source this cycle
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the granted source
//   gnt_vld : at least one request present
module ddr2_sys_rr_arbiter
  import ddr2_sys_ddr2_dmaster_st_channel_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  // Walk sources starting at rr_ptr; one extra bit lets the sum wrap
  // correctly for non-power-of-two NUM_CH.
  always_comb begin
    logic [PTR_W:0] pos;
    pos     = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_CH)) pos = pos - (PTR_W+1)'(NUM_CH);
      if (!gnt_vld && req[pos[PTR_W-1:0]]) begin
        gnt_vld                 = 1'b1;
        gnt[pos[PTR_W-1:0]]     = 1'b1;
        gnt_idx                 = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ddr2_sys_ddr2_dmaster_st_channel_arbiter.sv
// Packet-level round-robin merge of NUM_CH Avalon-ST byte sources into one
// channelised, registered stream (1-cycle latency). A grant is held from SOP
// to EOP; out_channel carries the source index.
//   clk, reset_n                : clock, async active-low reset
//   in_valid/in_ready/in_data/
//   in_startofpacket/in_endofpacket : per-source ST sinks (data packed per source)
//   out_ready/out_valid/out_data/out_channel/
//   out_startofpacket/out_endofpacket : merged ST source
//   drop_count                  : saturating count of discarded orphan beats
module ddr2_sys_ddr2_dmaster_st_channel_arbiter
  import ddr2_sys_ddr2_dmaster_st_channel_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_startofpacket,
  input  logic [NUM_CH-1:0]        in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [7:0]               drop_count
);

  localparam int PTR_W = $clog2(NUM_CH);

  arb_state_t        state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]  lock_ch, lock_ch_nxt;

  logic              ld;
  logic [NUM_CH-1:0] sop_req, orph_req, arb_gnt, sel_oh;
  logic [PTR_W-1:0]  arb_idx, orph_idx, sel_idx;
  logic              arb_vld, orph_vld, sel_vld, drop, xfer, fwd;
  logic              sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_CH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [NUM_CH-1:0] dec(input logic [PTR_W-1:0] p);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CH; i++) oh[i] = (p == PTR_W'(i));
    return oh;
  endfunction

  assign sop_req  = in_valid &  in_startofpacket;
  assign orph_req = in_valid & ~in_startofpacket;

  ddr2_sys_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req     (sop_req),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Orphans only drain when no SOP is waiting; lowest index first.
  always_comb begin
    orph_vld = 1'b0;
    orph_idx = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (orph_req[i]) begin
        orph_vld = 1'b1;
        orph_idx = PTR_W'(i);
      end
    end
  end

  // Source selection. While LOCKED the owner stays selected even with
  // valid low, so mid-packet gaps never reopen arbitration.
  always_comb begin
    ld      = !out_valid || out_ready;
    sel_vld = 1'b0;
    sel_idx = lock_ch;
    sel_oh  = '0;
    drop    = 1'b0;
    if (state == ST_LOCKED) begin
      sel_vld = 1'b1;
      sel_idx = lock_ch;
      sel_oh  = dec(lock_ch);
    end else if (arb_vld) begin
      sel_vld = 1'b1;
      sel_idx = arb_idx;
      sel_oh  = arb_gnt;
    end else if (orph_vld) begin
      sel_vld = 1'b1;
      sel_idx = orph_idx;
      sel_oh  = dec(orph_idx);
      drop    = 1'b1;
    end

    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_oh[i]) begin
        sel_valid = in_valid[i];
        sel_sop   = in_startofpacket[i];
        sel_eop   = in_endofpacket[i];
        sel_data  = in_data[i*DATA_W +: DATA_W];
      end
    end

    // reset_n gate keeps sources from seeing a handshake while held in reset.
    in_ready = (ld && sel_vld && reset_n) ? sel_oh : '0;
    xfer     = ld && sel_vld && sel_valid;
    fwd      = xfer && !drop;
  end

  // Packet FSM next state. A stray SOP while LOCKED is just another beat.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_ch_nxt = lock_ch;
    case (state)
      ST_IDLE: begin
        if (fwd) begin
          if (sel_eop) begin
            rr_ptr_nxt = nxt_ptr(sel_idx);
          end else begin
            state_nxt   = ST_LOCKED;
            lock_ch_nxt = sel_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (fwd && sel_eop) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = nxt_ptr(lock_ch);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (ld) begin
      out_valid <= fwd;
      if (fwd) begin
        out_data          <= sel_data;
        out_channel       <= CH_W'(sel_idx);
        out_startofpacket <= sel_sop;
        out_endofpacket   <= sel_eop;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          drop_count <= '0;
    else if (xfer && drop) drop_count <= sat_inc8(drop_count);
  end

endmodule
